sdram_responder: RTL
====================

Name: sdram_responder

Overview:
Synthesizable SDRAM device responder: the target end of the SDR SDRAM command interface driven by our sdram_controller. Decodes CS/RAS/CAS/WE commands sampled on posedge clk, tracks per-bank open rows and the mode register, and stores write data in a small on-chip array. Returns read data after the programmed CAS latency. Used as the DUT-side memory in controller benches and FPGA loopback builds; sticky protocol-error flags expose controller sequencing bugs.

Parameters:
ROW_WIDTH, 13, SDRAM row address bits
COL_WIDTH, 9, SDRAM column address bits
BANK_WIDTH, 2, bank address bits (fixed 4 banks)
SDRADDR_WIDTH, max(ROW_WIDTH,COL_WIDTH), addr bus width
MEM_ADDR_WIDTH, 10, log2 of stored words; index = low MEM_ADDR_WIDTH bits of {bank,row,col}, upper bits alias

Ports:
clk  in  1  clock; all sampling on posedge
rst  in  1  asynchronous reset, active-high
addr  in  SDRADDR_WIDTH  row/column/mode address; addr[10] = auto-precharge / precharge-all
bank_addr  in  BANK_WIDTH  bank select
data  inout  16  DQ bus; driven only during read data slot, else high-Z
clock_enable  in  1  CKE; low = command ignored, read pipeline frozen
cs_n, ras_n, cas_n, we_n  in  1 each  command strobes
data_mask_low, data_mask_high  in  1 each  write byte masks (1 = byte not written)
err  out  4  sticky protocol errors, cleared only by rst
ref_count  out  16  number of accepted REF commands, saturating at 16'hFFFF

Behaviour:
- Command decode {cs_n,ras_n,cas_n,we_n}: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 MRS. Commands are valid only when clock_enable=1.
- Reset (async): all banks closed; mode_valid=0; CL=3; read pipeline empty; data high-Z; err=0; ref_count=0; memory contents undefined.
- Per-bank state: IDLE or ACTIVE(row).
  - ACT: IDLE->ACTIVE(addr[ROW_WIDTH-1:0]).
  - PRE: addr[10]=1 closes all banks, else closes bank_addr. Closing an IDLE bank is legal.
- MRS: legal only with all banks IDLE, else err[2].
  - CL=addr[6:4] (2 or 3); BL=addr[2:0] must be 000; addr[9] ignored.
  - Illegal CL or BL: err[3], mode_valid stays 0.
  - Legal: mode_valid=1.
- REF with any bank ACTIVE: err[2], otherwise ref_count increments. No other effect.
- WRITE to ACTIVE bank: writes data into mem[{bank,row,addr[COL_WIDTH-1:0]}] on the same edge. Per-byte masking by data_mask_high/low. addr[10]=1 closes the bank after the write.
- READ to ACTIVE bank: pushes {index} into a 3-deep CL pipeline. DQ is driven with mem[index] from posedge k+CL-1 (k = READ edge) through posedge k+CL, so data is valid for sampling at edge k+CL. addr[10]=1 closes the bank at edge k. Data mask is not modelled on reads.
- READ/WRITE errors:
  - To an IDLE bank: err[0], no memory action.
  - With mode_valid=0: err[3], no memory action.
- ACT to an already ACTIVE bank: err[1], row unchanged.
- Back-to-back READs each get their own slot; consecutive slots keep DQ driven continuously.
- WRITE while read data is pending cancels all pending read slots, so DQ is not driven at the write edge.
- rst asserted mid-read: DQ goes high-Z asynchronously and the pipeline clears.
- clock_enable=0: command treated as NOP; pipeline and DQ drive hold their state.

Decomposition:
- Shared package sdram_pkg: command encodings (4-bit strobe patterns), err bit indices, mode-register field positions. sdram_controller will also use it.
- Sub-module sdram_resp_mem: 2^MEM_ADDR_WIDTH x 16 array with byte write enables and combinational read.
- Top level holds the decoder, bank tracker, CL pipeline, tristate and error logic.

Test Plan:
- Sequence: PRE all, 2xREF, MRS addr=10'b1000110000, ACT bank1 row5, WRITE col3 data 16'hBEEF addr[10]=0, READ col3 at edge k -> DQ=16'hBEEF sampled at edge k+3, high-Z at k+4; ref_count=2; err=0.
- MRS with CL=2; WRITE 16'h1234 then READ -> data at edge k+2; back-to-back READs of cols 0,1 -> continuous DQ over two slots.
- WRITE 16'hAAAA, then WRITE 16'h5555 with data_mask_high=1 to the same column; READ -> 16'hAA55.
- READ with addr[10]=1, then READ to the same bank without ACT -> err[0] set; second READ produces no DQ drive.
- ACT bank2, then REF -> err[2]=1 and ref_count unchanged. Then ACT bank2 again -> err[1]=1.
- READ issued, rst asserted at edge k+1 -> DQ high-Z immediately, err=0, and a READ after reset without MRS -> err[3].

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command strobe encodings, error flag indices and
// mode-register field positions, used by both the responder and the controller.
`timescale 1ns/1ps
package sdram_pkg;

   // Strobe pattern {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CMD_MRS   = 4'b0000,
      CMD_REF   = 4'b0001,
      CMD_PRE   = 4'b0010,
      CMD_ACT   = 4'b0011,
      CMD_WRITE = 4'b0100,
      CMD_READ  = 4'b0101,
      CMD_NOP   = 4'b0111,
      CMD_DESEL = 4'b1111
   } sdram_cmd_t;

   localparam int ERR_BANK_IDLE   = 0;
   localparam int ERR_BANK_ACTIVE = 1;
   localparam int ERR_NOT_IDLE    = 2;
   localparam int ERR_MODE        = 3;

   localparam int MR_BL_LSB = 0;
   localparam int MR_BL_MSB = 2;
   localparam int MR_CL_LSB = 4;
   localparam int MR_CL_MSB = 6;
   localparam int AP_BIT    = 10;

   localparam int DQ_WIDTH  = 16;

   // Unlisted strobe patterns (e.g. burst terminate) and CKE low both act as NOP
   function automatic sdram_cmd_t decode_cmd(input logic cke, input logic [3:0] strobes);
      sdram_cmd_t cmd;
      cmd = CMD_NOP;
      if (!cke) begin
         cmd = CMD_NOP;
      end else if (strobes[3]) begin
         cmd = CMD_DESEL;
      end else begin
         case (strobes[2:0])
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_READ;
            3'b100:  cmd = CMD_WRITE;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_MRS;
            default: cmd = CMD_NOP;
         endcase
      end
      return cmd;
   endfunction

   function automatic logic mode_legal(input logic [2:0] cl, input logic [2:0] bl);
      return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
   endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Word store for the SDRAM responder: one array per byte lane so each lane has
// its own write enable, with a combinational read port.
`timescale 1ns/1ps
module sdram_resp_mem
   import sdram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic [1:0]            i_byte_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DQ_WIDTH-1:0]   i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DQ_WIDTH-1:0]   o_rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] r_lane [DEPTH];

         always_ff @(posedge i_clk) begin
            if (i_byte_we[gi]) begin
               r_lane[i_waddr] <= i_wdata[gi*8 +: 8];
            end
         end

         assign o_rdata[gi*8 +: 8] = r_lane[i_raddr];
      end
   endgenerate

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM target model: command decode, per-bank row tracking, mode register,
// CAS-latency read pipeline driving DQ, and sticky protocol-error flags.
`timescale 1ns/1ps
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int ROW_WIDTH      = 13,
   parameter int COL_WIDTH      = 9,
   parameter int BANK_WIDTH     = 2,
   parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SDRADDR_WIDTH-1:0] addr,
   input  logic [BANK_WIDTH-1:0]    bank_addr,
   inout  wire  [DQ_WIDTH-1:0]      data,
   input  logic                     clock_enable,
   input  logic                     cs_n,
   input  logic                     ras_n,
   input  logic                     cas_n,
   input  logic                     we_n,
   input  logic                     data_mask_low,
   input  logic                     data_mask_high,
   output logic [3:0]               err,
   output logic [15:0]              ref_count
);

   localparam int NUM_BANKS  = 1 << BANK_WIDTH;
   localparam int FULL_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

   sdram_cmd_t w_cmd;

   logic [NUM_BANKS-1:0]      r_bank_active;
   logic [ROW_WIDTH-1:0]      r_bank_row [NUM_BANKS];
   logic                      r_mode_valid;
   logic [2:0]                r_cas_lat;
   logic [1:0]                r_pipe_valid;
   logic [MEM_ADDR_WIDTH-1:0] r_pipe_idx [2];
   logic                      r_drv_valid;
   logic [DQ_WIDTH-1:0]       r_dq_data;
   logic [3:0]                r_err;
   logic [15:0]               r_ref_count;

   logic                      w_sel_active;
   logic                      w_any_active;
   logic                      w_rw_ok;
   logic                      w_auto_pre;
   logic                      w_write_ok;
   logic [2:0]                w_mr_cl;
   logic [2:0]                w_mr_bl;
   logic                      w_mr_legal;
   logic [FULL_WIDTH-1:0]     w_full_addr;
   logic [MEM_ADDR_WIDTH-1:0] w_index;
   logic [1:0]                w_byte_we;
   logic [DQ_WIDTH-1:0]       w_rd_data;
   logic                      w_unused;

   assign w_cmd        = decode_cmd(clock_enable, {cs_n, ras_n, cas_n, we_n});
   assign w_sel_active = r_bank_active[bank_addr];
   assign w_any_active = |r_bank_active;
   assign w_rw_ok      = w_sel_active & r_mode_valid;
   assign w_auto_pre   = addr[AP_BIT];
   assign w_mr_cl      = addr[MR_CL_MSB:MR_CL_LSB];
   assign w_mr_bl      = addr[MR_BL_MSB:MR_BL_LSB];
   assign w_mr_legal   = mode_legal(w_mr_cl, w_mr_bl);

   // Upper bits of {bank,row,col} alias onto the small store
   assign w_full_addr  = {bank_addr, r_bank_row[bank_addr], addr[COL_WIDTH-1:0]};
   assign w_index      = w_full_addr[MEM_ADDR_WIDTH-1:0];
   assign w_write_ok   = (w_cmd == CMD_WRITE) && w_rw_ok;
   assign w_byte_we    = {2{w_write_ok}} & ~{data_mask_high, data_mask_low};

   assign w_unused     = ^{w_full_addr, addr};

   sdram_resp_mem #(
      .ADDR_WIDTH (MEM_ADDR_WIDTH)
   ) u_mem (
      .i_clk     (clk),
      .i_byte_we (w_byte_we),
      .i_waddr   (w_index),
      .i_wdata   (data),
      .i_raddr   (r_pipe_idx[0]),
      .o_rdata   (w_rd_data)
   );

   // A WRITE on the bus releases DQ immediately so the write edge never sees contention
   assign data      = (r_drv_valid && (w_cmd != CMD_WRITE)) ? r_dq_data : {DQ_WIDTH{1'bz}};
   assign err       = r_err;
   assign ref_count = r_ref_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank_active <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_bank_row[i] <= '0;
         end
         r_mode_valid  <= 1'b0;
         r_cas_lat     <= 3'd3;
         r_pipe_valid  <= '0;
         r_pipe_idx[0] <= '0;
         r_pipe_idx[1] <= '0;
         r_drv_valid   <= 1'b0;
         r_dq_data     <= '0;
         r_err         <= '0;
         r_ref_count   <= '0;
      end else if (clock_enable) begin
         // Slot 1 -> slot 0 -> DQ drive; a new read enters so it drives after CL-1 edges
         r_drv_valid   <= r_pipe_valid[0];
         r_dq_data     <= w_rd_data;
         r_pipe_valid  <= {1'b0, r_pipe_valid[1]};
         r_pipe_idx[0] <= r_pipe_idx[1];

         case (w_cmd)
            CMD_ACT: begin
               if (w_sel_active) begin
                  r_err[ERR_BANK_ACTIVE] <= 1'b1;
               end else begin
                  r_bank_active[bank_addr] <= 1'b1;
                  r_bank_row[bank_addr]    <= addr[ROW_WIDTH-1:0];
               end
            end
            CMD_PRE: begin
               if (w_auto_pre) begin
                  r_bank_active <= '0;
               end else begin
                  r_bank_active[bank_addr] <= 1'b0;
               end
            end
            CMD_REF: begin
               if (w_any_active) begin
                  r_err[ERR_NOT_IDLE] <= 1'b1;
               end else if (r_ref_count != 16'hFFFF) begin
                  r_ref_count <= r_ref_count + 16'd1;
               end
            end
            CMD_MRS: begin
               if (w_any_active) begin
                  r_err[ERR_NOT_IDLE] <= 1'b1;
               end else if (w_mr_legal) begin
                  r_mode_valid <= 1'b1;
                  r_cas_lat    <= w_mr_cl;
               end else begin
                  r_err[ERR_MODE] <= 1'b1;
               end
            end
            CMD_WRITE, CMD_READ: begin
               if (!w_sel_active) begin
                  r_err[ERR_BANK_IDLE] <= 1'b1;
               end
               if (!r_mode_valid) begin
                  r_err[ERR_MODE] <= 1'b1;
               end
               if (w_rw_ok && w_auto_pre) begin
                  r_bank_active[bank_addr] <= 1'b0;
               end
               if (w_cmd == CMD_WRITE) begin
                  r_pipe_valid <= '0;
                  r_drv_valid  <= 1'b0;
               end else if (w_rw_ok) begin
                  if (r_cas_lat == 3'd2) begin
                     r_pipe_valid[0] <= 1'b1;
                     r_pipe_idx[0]   <= w_index;
                  end else begin
                     r_pipe_valid[1] <= 1'b1;
                     r_pipe_idx[1]   <= w_index;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
